apb_regbus_slave: RTL and testbench

Parametrised APB4 slave bridging the system APB bus to a generic register-bank request/acknowledge port. It supports:
- wait states driven by the downstream register logic;
- PSLVERR on out-of-range or misaligned addresses;
- byte strobes;
- an optional wait-state timeout.

It sits between the APB interconnect and any POLI register bank (NAND/NOR, XOR/BUF, CRC and future blocks), replacing fixed-latency, no-error address decoding.

---
 rtl/POLI_types_pkg.sv | 15 +
 rtl/apb_addr_decode.sv | 38 +++
 rtl/apb_regbus_slave.sv | 188 ++++++++++++++++++
 tb/tb_apb_regbus_slave.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/POLI_types_pkg.sv
// Shared types for POLI register-bank bus adapters.
package POLI_types_pkg;

  // APB-to-regbus bridge transfer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } apb_regbus_state_t;

  // Fill value for PRDATA on errored or non-read responses (replicate to DATA_W)
  localparam bit APB_ERR_RDATA = 1'b0;

endpackage : POLI_types_pkg

// File: rtl/apb_addr_decode.sv
// Combinational APB byte-address decoder for a word-register window starting
// at BASE_ADDR: flags range/alignment validity and returns the word index.
module apb_addr_decode #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       NREGS     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic [ADDR_W-1:0]        paddr,
  output logic                     valid_c,
  output logic [$clog2(NREGS)-1:0] idx_c
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned LSB   = $clog2(BYTES);
  localparam int unsigned IDX_W = $clog2(NREGS);
  localparam int unsigned EXT_W = ADDR_W + 1;

  // One extra bit so BASE_ADDR + window size cannot wrap at the top of the map
  localparam logic [EXT_W-1:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [EXT_W-1:0] LIMIT_EXT = BASE_EXT + EXT_W'(NREGS * BYTES);

  logic [EXT_W-1:0]  paddr_ext;
  logic [ADDR_W-1:0] offset;
  logic              in_range;
  logic              aligned;

  // Range check, word alignment check and index extraction
  always_comb begin
    paddr_ext = {1'b0, paddr};
    offset    = paddr - BASE_ADDR;
    in_range  = (paddr_ext >= BASE_EXT) && (paddr_ext < LIMIT_EXT);
    aligned   = (paddr & ADDR_W'(BYTES - 1)) == '0;
    valid_c   = in_range && aligned;
    idx_c     = IDX_W'(offset >> LSB);
  end

endmodule : apb_addr_decode

// File: rtl/apb_regbus_slave.sv
// APB4 slave bridging to a register-bank request/acknowledge port.
// Valid accesses issue a one-cycle reg_wr/reg_rd and wait for reg_ack;
// out-of-range or misaligned accesses complete with PSLVERR and no strobe.
// Optional wait-state timeout: define APB_REGBUS_TIMEOUT_EN.
module apb_regbus_slave
  import POLI_types_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       NREGS     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned       TIMEOUT   = 15
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [ADDR_W-1:0]        PADDR,
  input  logic [DATA_W-1:0]        PWDATA,
  input  logic [DATA_W/8-1:0]      PSTRB,
  output logic [DATA_W-1:0]        PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERR,
  output logic [$clog2(NREGS)-1:0] reg_idx,
  output logic                     reg_wr,
  output logic                     reg_rd,
  output logic [DATA_W-1:0]        reg_wdata,
  output logic [DATA_W/8-1:0]      reg_wstrb,
  input  logic [DATA_W-1:0]        reg_rdata,
  input  logic                     reg_ack,
  input  logic                     reg_err
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = $clog2(NREGS);

  // Reject parameterisations the datapath cannot represent
  if (NREGS < 2 || (DATA_W % 8) != 0 || DATA_W == 0 || TIMEOUT < 1) begin : g_param_check
    $error("apb_regbus_slave: unsupported parameter set");
  end

  apb_regbus_state_t state_q, state_d;

  logic              wr_q, wr_d;
  logic              dec_valid_c;
  logic [IDX_W-1:0]  dec_idx_c;

  logic [DATA_W-1:0] prdata_d;
  logic              pready_d;
  logic              pslverr_d;
  logic [IDX_W-1:0]  reg_idx_d;
  logic              reg_wr_d;
  logic              reg_rd_d;
  logic [DATA_W-1:0] reg_wdata_d;
  logic [STRB_W-1:0] reg_wstrb_d;

`ifdef APB_REGBUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  apb_addr_decode #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .NREGS     (NREGS),
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_decode (
    .paddr   (PADDR),
    .valid_c (dec_valid_c),
    .idx_c   (dec_idx_c)
  );

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    prdata_d    = {DATA_W{APB_ERR_RDATA}};
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    reg_idx_d   = reg_idx;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    reg_wdata_d = reg_wdata;
    reg_wstrb_d = reg_wstrb;
`ifdef APB_REGBUS_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          wr_d        = PWRITE;
          reg_idx_d   = dec_idx_c;
          reg_wdata_d = PWDATA;
          reg_wstrb_d = PSTRB;
          if (dec_valid_c) begin
            state_d  = REQ;
            reg_wr_d = PWRITE;
            reg_rd_d = !PWRITE;
`ifdef APB_REGBUS_TIMEOUT_EN
            cnt_d    = '0;
`endif
          end else begin
            // Bad address answers immediately, nothing reaches the bank
            state_d   = RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end
        end
      end

      REQ, WAIT: begin
        if (!PSEL) begin
          // Master dropped the transfer: abandon it silently
          state_d = IDLE;
        end else if (reg_ack) begin
          state_d   = RESP;
          pready_d  = 1'b1;
          pslverr_d = reg_err;
          if (!wr_q && !reg_err) begin
            prdata_d = reg_rdata;
          end
        end else begin
`ifdef APB_REGBUS_TIMEOUT_EN
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d   = RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else begin
            state_d = WAIT;
          end
          cnt_d = cnt_q + CNT_W'(1);
`else
          state_d = WAIT;
`endif
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      wr_q      <= 1'b0;
      PRDATA    <= '0;
      PREADY    <= 1'b0;
      PSLVERR   <= 1'b0;
      reg_idx   <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      reg_wdata <= '0;
      reg_wstrb <= '0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      PRDATA    <= prdata_d;
      PREADY    <= pready_d;
      PSLVERR   <= pslverr_d;
      reg_idx   <= reg_idx_d;
      reg_wr    <= reg_wr_d;
      reg_rd    <= reg_rd_d;
      reg_wdata <= reg_wdata_d;
      reg_wstrb <= reg_wstrb_d;
    end
  end

`ifdef APB_REGBUS_TIMEOUT_EN
  // Wait-state counter, cleared on entry to REQ
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule : apb_regbus_slave

// File: tb/tb_apb_regbus_slave.sv
// Directed bench for apb_regbus_slave: APB master tasks, a programmable
// register-bank responder and strobe/PREADY pulse monitors.
module tb_apb_regbus_slave;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREGS  = 16;
  localparam logic [31:0] BASE   = 32'h8000_0000;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [3:0]  PSTRB = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [3:0]  reg_idx;
  logic        reg_wr;
  logic        reg_rd;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic [31:0] reg_rdata = '0;
  logic        reg_ack = 1'b0;
  logic        reg_err = 1'b0;

  apb_regbus_slave #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREGS(NREGS), .BASE_ADDR(BASE), .TIMEOUT(15)
  ) dut (
    .CLK(CLK), .nRST(nRST), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .reg_idx(reg_idx), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb), .reg_rdata(reg_rdata),
    .reg_ack(reg_ack), .reg_err(reg_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Responder: ack resp_delay cycles after a request (0 = same cycle, <0 = never)
  int          resp_delay = 0;
  logic [31:0] resp_rdata = '0;
  logic        resp_err   = 1'b0;

  always begin
    @(posedge CLK); #1;
    if (reg_wr || reg_rd) begin
      if (resp_delay >= 0) begin
        for (int i = 0; i < resp_delay; i++) begin
          @(posedge CLK); #1;
        end
        reg_ack   = 1'b1;
        reg_rdata = resp_rdata;
        reg_err   = resp_err;
        @(posedge CLK); #1;
        reg_ack   = 1'b0;
        reg_rdata = '0;
        reg_err   = 1'b0;
      end
    end
  end

  // Pulse monitors
  int          n_wr = 0, n_rd = 0, n_ready = 0;
  logic [3:0]  last_idx = '0;
  logic [31:0] last_wdata = '0;
  logic [3:0]  last_wstrb = '0;

  always @(negedge CLK) begin
    if (reg_wr) begin
      n_wr++;
      last_idx   = reg_idx;
      last_wdata = reg_wdata;
      last_wstrb = reg_wstrb;
    end
    if (reg_rd) begin
      n_rd++;
      last_idx = reg_idx;
    end
    if (PREADY) n_ready++;
  end

  task automatic apb_setup(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output int setup_cyc);
    @(posedge CLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data; PSTRB = strb;
    setup_cyc = cyc;
    @(posedge CLK); #1;
    PENABLE = 1'b1;
  endtask

  task automatic apb_wait(input int max_cyc, output logic got, output int done_cyc,
                          output logic [31:0] rdata, output logic err);
    got = 1'b0; done_cyc = 0; rdata = '0; err = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge CLK);
      if (PREADY) begin
        got = 1'b1; done_cyc = cyc; rdata = PRDATA; err = PSLVERR;
      end
    end
  endtask

  task automatic apb_end();
    @(posedge CLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic got, output int lat,
                          output logic [31:0] rdata, output logic err);
    int c0, done;
    apb_setup(wr, addr, data, strb, c0);
    apb_wait(40, got, done, rdata, err);
    lat = done - c0;
    apb_end();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        got, err;
    logic [31:0] rdata;
    int          lat, c0, done, wr0, rd0, rdy0;

    // Reset values
    repeat (3) @(posedge CLK);
    #1;
    check("rst_pready",  32'(PREADY),    32'd0);
    check("rst_pslverr", 32'(PSLVERR),   32'd0);
    check("rst_prdata",  PRDATA,         32'd0);
    check("rst_reg_wr",  32'(reg_wr),    32'd0);
    check("rst_reg_rd",  32'(reg_rd),    32'd0);
    check("rst_idx",     32'(reg_idx),   32'd0);
    check("rst_wdata",   reg_wdata,      32'd0);
    check("rst_wstrb",   32'(reg_wstrb), 32'd0);
    @(negedge CLK) nRST = 1'b1;

    // Write BASE+8, ack in the request cycle
    resp_delay = 0; resp_rdata = 32'h0; resp_err = 1'b0;
    wr0 = n_wr; rd0 = n_rd; rdy0 = n_ready;
    apb_xfer(1'b1, BASE + 32'd8, 32'hDEAD_BEEF, 4'hF, got, lat, rdata, err);
    check("w8_ready",  32'(got),        32'd1);
    check("w8_lat",    lat,             32'd2);
    check("w8_err",    32'(err),        32'd0);
    check("w8_nwr",    n_wr - wr0,      32'd1);
    check("w8_nrd",    n_rd - rd0,      32'd0);
    check("w8_idx",    32'(last_idx),   32'd2);
    check("w8_wdata",  last_wdata,      32'hDEAD_BEEF);
    check("w8_wstrb",  32'(last_wstrb), 32'hF);
    check("w8_nready", n_ready - rdy0,  32'd1);

    // Read BASE+4, ack three cycles after the request
    resp_delay = 3; resp_rdata = 32'h1234_5678; resp_err = 1'b0;
    rd0 = n_rd; rdy0 = n_ready;
    apb_xfer(1'b0, BASE + 32'd4, 32'h0, 4'h0, got, lat, rdata, err);
    check("r4_ready",  32'(got),       32'd1);
    check("r4_lat",    lat,            32'd5);
    check("r4_rdata",  rdata,          32'h1234_5678);
    check("r4_err",    32'(err),       32'd0);
    check("r4_nrd",    n_rd - rd0,     32'd1);
    check("r4_idx",    32'(last_idx),  32'd1);
    check("r4_nready", n_ready - rdy0, 32'd1);

    // Partial-strobe write to the last register
    resp_delay = 0;
    wr0 = n_wr;
    apb_xfer(1'b1, BASE + 32'd60, 32'h0102_0304, 4'h5, got, lat, rdata, err);
    check("w60_lat",   lat,             32'd2);
    check("w60_err",   32'(err),        32'd0);
    check("w60_nwr",   n_wr - wr0,      32'd1);
    check("w60_idx",   32'(last_idx),   32'd15);
    check("w60_wstrb", 32'(last_wstrb), 32'h5);

    // Read one past the window
    resp_delay = 0; resp_rdata = 32'hAAAA_5555;
    wr0 = n_wr; rd0 = n_rd;
    apb_xfer(1'b0, BASE + 32'd64, 32'h0, 4'h0, got, lat, rdata, err);
    check("r64_lat",   lat,         32'd1);
    check("r64_err",   32'(err),    32'd1);
    check("r64_rdata", rdata,       32'd0);
    check("r64_nrd",   n_rd - rd0,  32'd0);
    check("r64_nwr",   n_wr - wr0,  32'd0);

    // Misaligned write
    wr0 = n_wr;
    apb_xfer(1'b1, BASE + 32'd2, 32'hFFFF_FFFF, 4'hF, got, lat, rdata, err);
    check("w2_lat", lat,        32'd1);
    check("w2_err", 32'(err),   32'd1);
    check("w2_nwr", n_wr - wr0, 32'd0);

    // Read just below the window
    rd0 = n_rd;
    apb_xfer(1'b0, BASE - 32'd4, 32'h0, 4'h0, got, lat, rdata, err);
    check("rlo_err", 32'(err),   32'd1);
    check("rlo_nrd", n_rd - rd0, 32'd0);

    // Read acknowledged with a downstream error
    resp_delay = 1; resp_rdata = 32'hFFFF_0000; resp_err = 1'b1;
    apb_xfer(1'b0, BASE + 32'd20, 32'h0, 4'h0, got, lat, rdata, err);
    check("rerr_lat",   lat,      32'd3);
    check("rerr_err",   32'(err), 32'd1);
    check("rerr_rdata", rdata,    32'd0);
    resp_err = 1'b0;

`ifdef APB_REGBUS_TIMEOUT_EN
    // No timely ack: timeout response, then a late ack is ignored
    resp_delay = 20; resp_rdata = 32'h7777_7777;
    rd0 = n_rd; rdy0 = n_ready;
    apb_xfer(1'b0, BASE + 32'd12, 32'h0, 4'h0, got, lat, rdata, err);
    check("to_ready", 32'(got), 32'd1);
    check("to_lat",   lat,      32'd16);
    check("to_err",   32'(err), 32'd1);
    check("to_rdata", rdata,    32'd0);
    repeat (15) @(posedge CLK);
    #1;
    check("to_nready", n_ready - rdy0, 32'd1);
    check("to_nrd",    n_rd - rd0,     32'd1);
`else
    // No ack: transfer stalls indefinitely until the master drops PSEL
    resp_delay = -1;
    rd0 = n_rd; rdy0 = n_ready;
    apb_setup(1'b0, BASE + 32'd12, 32'h0, 4'h0, c0);
    apb_wait(100, got, done, rdata, err);
    check("nto_ready", 32'(got), 32'd0);
    apb_end();
    repeat (3) @(posedge CLK);
    #1;
    check("nto_nready", n_ready - rdy0, 32'd0);
    check("nto_nrd",    n_rd - rd0,     32'd1);
`endif

    // Asynchronous reset while waiting for ack
    resp_delay = -1;
    apb_setup(1'b1, BASE + 32'd12, 32'hCAFE_F00D, 4'h3, c0);
    repeat (3) @(posedge CLK);
    #1;
    check("pre_idx",   32'(reg_idx), 32'd3);
    check("pre_wdata", reg_wdata,    32'hCAFE_F00D);
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    check("ar_pready",  32'(PREADY),    32'd0);
    check("ar_pslverr", 32'(PSLVERR),   32'd0);
    check("ar_prdata",  PRDATA,         32'd0);
    check("ar_idx",     32'(reg_idx),   32'd0);
    check("ar_wdata",   reg_wdata,      32'd0);
    check("ar_wstrb",   32'(reg_wstrb), 32'd0);
    check("ar_wr_rd",   32'({reg_wr, reg_rd}), 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;

    // Normal transfer after reset
    resp_delay = 1; resp_rdata = 32'h55AA_33CC; resp_err = 1'b0;
    rd0 = n_rd;
    apb_xfer(1'b0, BASE, 32'h0, 4'h0, got, lat, rdata, err);
    check("post_ready", 32'(got),      32'd1);
    check("post_lat",   lat,           32'd3);
    check("post_rdata", rdata,         32'h55AA_33CC);
    check("post_err",   32'(err),      32'd0);
    check("post_idx",   32'(last_idx), 32'd0);
    check("post_nrd",   n_rd - rd0,    32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule : tb_apb_regbus_slave
